// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/grant/response, execute-stage
// redirect, and the valid/ready instruction hand-off to the decoder.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  jump_en, jump_addr,
    output inst_valid, inst, inst_addr,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output jump_en, jump_addr,
    input  inst_valid, inst, inst_addr,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, keeps up to DEPTH requests/words in an
// in-order queue, drops responses belonging to a redirected-away stream.
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]      pc_q;
  logic [31:0]      slot_addr_q [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] fill_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] discard_q;

  logic [CNT_W:0]   occ;
  logic [CNT_W:0]   redirect_sum;
  logic [CNT_W-1:0] discard_redirect;
  logic             req;
  logic             grant;
  logic             valid;
  logic             pop;
  logic             drop;
  logic             fill_en;

  // Credits come from registered state only, so a same-cycle pop never frees one.
  always_comb begin
    occ          = {1'b0, count_q} + {1'b0, discard_q};
    req          = rst & (occ < DEPTH_OCC) & ~bus.jump_en;
    grant        = req & bus.mem_gnt;
    valid        = (count_q != '0) & filled_q[head_q];
    pop          = valid & bus.inst_ready;
    drop         = bus.mem_rvalid & (discard_q != '0);
    fill_en      = bus.mem_rvalid & (discard_q == '0) & (pend_q != '0) & ~bus.jump_en;
    redirect_sum = {1'b0, pend_q} + {1'b0, discard_q};
    if (bus.mem_rvalid && (redirect_sum != '0))
      redirect_sum = redirect_sum - 1'b1;
    discard_redirect = redirect_sum[CNT_W-1:0];
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? slot_data_q[head_q] : NOP;
  assign bus.inst_addr  = valid ? slot_addr_q[head_q] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_ADDR;
      filled_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= '0;
    end else if (bus.jump_en) begin
      // Every reserved-but-unfilled slot still owes a response that must be eaten.
      pc_q      <= {bus.jump_addr[31:2], 2'b00};
      filled_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= discard_redirect;
    end else begin
      if (grant) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= ptr_inc(tail_q);
      end
      if (drop)
        discard_q <= discard_q - 1'b1;
      if (fill_en) begin
        filled_q[fill_q] <= 1'b1;
        fill_q           <= ptr_inc(fill_q);
      end
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      count_q <= count_q + CNT_W'(grant) - CNT_W'(pop);
      pend_q  <= pend_q + CNT_W'(grant) - CNT_W'(fill_en);
    end
  end

  // Slot payload needs no reset: it is only visible behind filled_q.
  always_ff @(posedge clk) begin
    if (grant)
      slot_addr_q[tail_q] <= pc_q;
    if (fill_en)
      slot_data_q[fill_q] <= bus.mem_rdata;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] XORK  = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inst_fetch_if bus ();
  inst_fetch_if bw ();

  inst_fetch #(.RESET_ADDR(32'h0000_0000), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  inst_fetch #(.RESET_ADDR(32'hFFFF_FFF8), .DEPTH(DEPTH), .NOP(NOP)) u_wrap (
    .clk(clk), .rst(rst), .bus(bw)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ngrant;

  // reference model: filled words, outstanding addresses, responses to drop
  logic [31:0] m_pc;
  logic [31:0] out_a[$];
  logic [31:0] out_d[$];
  logic [31:0] pend[$];
  int          disc;

  // memory responder and consumed-instruction log
  logic [31:0] mq_a[$];
  int          mq_t[$];
  logic [31:0] hs_a[$];
  logic [31:0] hs_d[$];
  logic [31:0] wq[$];
  logic [31:0] wgr[$];
  logic [31:0] whs[$];
  logic [31:0] whs_d[$];

  int          gnt_mode;
  int          rv_mode;
  int          lat_max;
  logic        drv_ready;
  logic        drv_jump;
  logic [31:0] drv_jaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    tests++;
    fails++;
    $display("FAIL %s: cycle budget exhausted (cycle %0d)", name, cyc);
  endtask

  task automatic idle_inputs();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.jump_en = 1'b0; bus.jump_addr = 32'h0; bus.inst_ready = 1'b0;
    bw.mem_gnt = 1'b0;  bw.mem_rvalid = 1'b0;  bw.mem_rdata = 32'h0;
    bw.jump_en = 1'b0;  bw.jump_addr = 32'h0;  bw.inst_ready = 1'b0;
  endtask

  task automatic do_reset(input bit keep_inflight);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
    chk("rst_inst", bus.inst, NOP);
    chk("rst_inst_addr", bus.inst_addr, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    out_a.delete(); out_d.delete(); pend.delete();
    disc = 0;
    m_pc = 32'h0;
    if (!keep_inflight) begin
      mq_a.delete(); mq_t.delete();
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, advance model.
  task automatic cycle();
    logic        m_req, m_valid, gnt, rv;
    logic [31:0] rdata;
    int          occ;
    @(negedge clk);
    occ     = out_a.size() + pend.size() + disc;
    m_req   = (occ < DEPTH) && !drv_jump;
    m_valid = (out_a.size() > 0);
    case (gnt_mode)
      0:       gnt = 1'b0;
      1:       gnt = 1'b1;
      default: gnt = ($urandom_range(0, 99) < 60);
    endcase
    rv    = 1'b0;
    rdata = $urandom;
    if (rv_mode != 0 && mq_a.size() > 0 && mq_t[0] <= cyc &&
        (rv_mode == 1 || $urandom_range(0, 99) < 60)) begin
      rv    = 1'b1;
      rdata = mq_a[0] ^ XORK;
    end
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
    bus.jump_en    = drv_jump;
    bus.jump_addr  = drv_jaddr;
    bus.inst_ready = drv_ready;
    #1;
    chk("mem_req", {31'h0, bus.mem_req}, {31'h0, m_req});
    chk("mem_addr", bus.mem_addr, m_pc);
    chk("inst_valid", {31'h0, bus.inst_valid}, {31'h0, m_valid});
    chk("inst", bus.inst, m_valid ? out_d[0] : NOP);
    chk("inst_addr", bus.inst_addr, m_valid ? out_a[0] : 32'h0);
    if (occ >= DEPTH) chk("req_when_full", {31'h0, bus.mem_req}, 32'h0);

    if (rv) begin
      void'(mq_a.pop_front());
      void'(mq_t.pop_front());
    end
    if (m_valid && drv_ready) begin
      hs_a.push_back(out_a[0]);
      hs_d.push_back(out_d[0]);
    end
    if (drv_jump) begin
      int nd = pend.size() + disc - (rv ? 1 : 0);
      disc = (nd < 0) ? 0 : nd;
      out_a.delete(); out_d.delete(); pend.delete();
      m_pc = {drv_jaddr[31:2], 2'b00};
    end else begin
      if (m_valid && drv_ready) begin
        void'(out_a.pop_front());
        void'(out_d.pop_front());
      end
      if (rv) begin
        if (disc > 0) disc--;
        else if (pend.size() > 0) begin
          out_a.push_back(pend.pop_front());
          out_d.push_back(rdata);
        end
      end
      if (m_req && gnt) begin
        pend.push_back(m_pc);
        mq_a.push_back(m_pc);
        mq_t.push_back(cyc + $urandom_range(1, lat_max));
        ngrant++;
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    gnt_mode = 0; rv_mode = 0; lat_max = 1;
    drv_ready = 1'b0; drv_jump = 1'b0; drv_jaddr = 32'h0;
    ngrant = 0;
    do_reset(1'b0);

    // streaming with 1-cycle memory
    gnt_mode = 1; rv_mode = 1; lat_max = 1; drv_ready = 1'b1;
    hs_a.delete(); hs_d.delete();
    for (int i = 0; i < 40 && hs_a.size() < 3; i++) cycle();
    if (hs_a.size() < 3) expired("stream_first3");
    else begin
      chk("stream_addr0", hs_a[0], 32'h0000_0000);
      chk("stream_addr1", hs_a[1], 32'h0000_0004);
      chk("stream_addr2", hs_a[2], 32'h0000_0008);
      chk("stream_data0", hs_d[0], 32'hA5A5_A5A5);
      chk("stream_data1", hs_d[1], 32'hA5A5_A5A1);
      chk("stream_data2", hs_d[2], 32'hA5A5_A5AD);
    end

    // back-pressure: only DEPTH grants, then drain in order
    do_reset(1'b0);
    drv_ready = 1'b0; ngrant = 0;
    repeat (10) cycle();
    chk("stall_grants", ngrant, 32'd2);
    chk("stall_req_low", {31'h0, bus.mem_req}, 32'h0);
    rv_mode = 0; drv_ready = 1'b1;
    hs_a.delete(); hs_d.delete();
    for (int i = 0; i < 20 && hs_a.size() < 2; i++) cycle();
    if (hs_a.size() < 2) expired("stall_drain");
    else begin
      chk("drain_addr0", hs_a[0], 32'h0000_0000);
      chk("drain_addr1", hs_a[1], 32'h0000_0004);
    end
    for (int i = 0; i < 20 && pend.size() < 2; i++) cycle();
    if (pend.size() < 2) expired("inflight_two");
    else begin
      chk("inflight0", pend[0], 32'h0000_0008);
      chk("inflight1", pend[1], 32'h0000_000C);
    end

    // redirect with two responses in flight
    drv_jump = 1'b1; drv_jaddr = 32'h0000_0103;
    cycle();
    drv_jump = 1'b0;
    @(posedge clk);
    #1;
    chk("redir_mem_addr", bus.mem_addr, 32'h0000_0100);
    chk("redir_discard", disc, 32'd2);
    rv_mode = 1;
    hs_a.delete(); hs_d.delete();
    for (int i = 0; i < 40 && hs_a.size() < 1; i++) cycle();
    if (hs_a.size() < 1) expired("redir_first");
    else begin
      chk("redir_first_addr", hs_a[0], 32'h0000_0100);
      chk("redir_first_data", hs_d[0], 32'hA5A5_A4A5);
    end

    // redirect coinciding with a response and an ID handshake
    do_reset(1'b0);
    gnt_mode = 1; rv_mode = 1; lat_max = 1; drv_ready = 1'b0;
    hs_a.delete(); hs_d.delete();
    for (int i = 0; i < 20; i++) begin
      if (out_a.size() == 1 && pend.size() == 1 && mq_t.size() > 0 && mq_t[0] <= cyc) break;
      cycle();
    end
    if (!(out_a.size() == 1 && pend.size() == 1 && mq_t.size() > 0 && mq_t[0] <= cyc))
      expired("coincide_setup");
    else begin
      drv_jump = 1'b1; drv_jaddr = 32'h0000_0040; drv_ready = 1'b1;
      cycle();
      drv_jump = 1'b0;
      chk("coincide_consumed_n", hs_a.size(), 32'd1);
      if (hs_a.size() > 0) chk("coincide_consumed_addr", hs_a[0], 32'h0000_0000);
      chk("coincide_discard", disc, 32'd0);
      for (int i = 0; i < 40 && hs_a.size() < 2; i++) cycle();
      if (hs_a.size() < 2) expired("coincide_target");
      else chk("coincide_target_addr", hs_a[1], 32'h0000_0040);
    end

    // asynchronous reset with two requests outstanding
    do_reset(1'b0);
    gnt_mode = 1; rv_mode = 0; lat_max = 3; drv_ready = 1'b1;
    for (int i = 0; i < 20 && pend.size() < 2; i++) cycle();
    if (pend.size() < 2) expired("midreset_setup");
    do_reset(1'b1);
    gnt_mode = 0; rv_mode = 1;
    repeat (8) begin
      cycle();
      chk("midreset_no_valid", {31'h0, bus.inst_valid}, 32'h0);
    end
    chk("midreset_stale_delivered", mq_a.size(), 32'd0);

    // PC wrap from RESET_ADDR = 0xFFFF_FFF8 on the second instance
    do_reset(1'b0);
    bw.inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bw.mem_gnt    = 1'b1;
      bw.mem_rvalid = (wq.size() > 0);
      bw.mem_rdata  = (wq.size() > 0) ? (wq[0] ^ XORK) : 32'h0;
      #1;
      if (bw.mem_rvalid) void'(wq.pop_front());
      if (bw.mem_req) begin
        wq.push_back(bw.mem_addr);
        wgr.push_back(bw.mem_addr);
      end
      if (bw.inst_valid) begin
        whs.push_back(bw.inst_addr);
        whs_d.push_back(bw.inst);
      end
    end
    idle_inputs();
    if (wgr.size() < 3) expired("wrap_fetch");
    else begin
      chk("wrap_fetch0", wgr[0], 32'hFFFF_FFF8);
      chk("wrap_fetch1", wgr[1], 32'hFFFF_FFFC);
      chk("wrap_fetch2", wgr[2], 32'h0000_0000);
    end
    if (whs.size() < 3) expired("wrap_inst");
    else begin
      chk("wrap_inst_addr0", whs[0], 32'hFFFF_FFF8);
      chk("wrap_inst_addr1", whs[1], 32'hFFFF_FFFC);
      chk("wrap_inst_addr2", whs[2], 32'h0000_0000);
      chk("wrap_inst_data2", whs_d[2], 32'hA5A5_A5A5);
    end

    // randomized traffic with redirects
    do_reset(1'b0);
    gnt_mode = 2; rv_mode = 2; lat_max = 3;
    repeat (4000) begin
      drv_ready = ($urandom_range(0, 99) < 70);
      drv_jump  = ($urandom_range(0, 99) < 4);
      drv_jaddr = $urandom;
      if ($urandom_range(0, 3) == 0) drv_jaddr = 32'hFFFF_FFF0 | {28'h0, drv_jaddr[3:0]};
      cycle();
      drv_jump = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
